spi_reg_responder: RTL and testbench

SPI_REG_RESPONDER -- requirements
Module: spi_reg_responder

---
 rtl/spi_reg_responder_pkg.sv | 18 +
 rtl/sync_edge.sv | 44 ++++
 rtl/spi_reg_responder.sv | 212 +++++++++++++++++++++
 tb/tb_spi_reg_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_responder_pkg.sv
// Shared constants and types for the SPI register responder.
package spi_reg_responder_pkg;

    localparam int FRAME_LEN = 24;
    localparam int CMD_LEN   = 8;
    localparam int DATA_LEN  = 16;
    localparam int CNT_W     = 5;

    localparam logic [6:0] DEFAULT_STATUS_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one asynchronous input, plus rise/fall detection
// on the synchronized level.
module sync_edge
    import spi_reg_responder_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next values: shift the input through the metastability and edge stages.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Stage registers, forced to the bus idle level during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
            prev_q <= IDLE_LEVEL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI (CPOL=1, CPHA=0) slave giving 24-bit read/write access to a small
// 16-bit register file plus one read-only status word, oversampled by clk.
module spi_reg_responder
    import spi_reg_responder_pkg::*;
#(
    parameter int         N_REGS      = 16,
    parameter logic [6:0] STATUS_ADDR = DEFAULT_STATUS_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        n_cs,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [15:0] status_in,
    output logic        wr_valid,
    output logic [6:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [21:0]        rx_q, rx_d;
    logic [15:0]        tx_q, tx_d;
    logic               is_read_q, is_read_d;
    logic               miso_q, miso_d;
    logic               miso_oe_q, miso_oe_d;
    logic               wr_valid_q, wr_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [6:0]         wr_addr_q, wr_addr_d;
    logic [15:0]        wr_data_q, wr_data_d;
    logic [15:0]        regs_q [N_REGS];
    logic [15:0]        regs_d [N_REGS];
    logic               mosi_meta_q, mosi_meta_d;
    logic               mosi_sync_q, mosi_sync_d;
    logic [1:0]         settle_q, settle_d;
    logic               armed_q, armed_d;

    logic n_cs_level, n_cs_rise, n_cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;

    sync_edge #(.IDLE_LEVEL(1'b1)) u_sync_n_cs (
        .clk      (clk),
        .rst      (rst),
        .async_in (n_cs),
        .level    (n_cs_level),
        .rise     (n_cs_rise),
        .fall     (n_cs_fall)
    );

    sync_edge #(.IDLE_LEVEL(1'b1)) u_sync_sclk (
        .clk      (clk),
        .rst      (rst),
        .async_in (sclk),
        .level    (sclk_level),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    // A frame only starts once the bus has been seen idle after reset, so a
    // transfer already running when reset is released is skipped entirely.
    logic       start, in_frame, sample, last_cmd, last_bit, shift_out;
    logic [7:0] cmd_word;
    logic [6:0] frame_addr;
    logic [15:0] frame_data;
    logic [15:0] read_word;

    assign in_frame   = (state_q == ST_CMD) || (state_q == ST_DATA);
    assign start      = (state_q == ST_IDLE) && armed_q && n_cs_fall;
    assign sample     = in_frame && sclk_fall && !n_cs_rise;
    assign last_cmd   = sample && (state_q == ST_CMD) && (cnt_q == CNT_W'(CMD_LEN - 1));
    assign last_bit   = sample && (state_q == ST_DATA) && (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign shift_out  = (state_q == ST_DATA) && is_read_q && sclk_rise && !n_cs_rise;
    assign cmd_word   = {rx_q[6:0], mosi_sync_q};
    assign frame_addr = rx_q[21:15];
    assign frame_data = {rx_q[14:0], mosi_sync_q};

    // Read word selected from the address just completed in the command byte.
    always_comb begin
        read_word = 16'h0000;
        if (cmd_word[6:0] == STATUS_ADDR) begin
            read_word = status_in;
        end
        for (int i = 0; i < N_REGS; i++) begin
            if (cmd_word[6:0] == 7'(i)) begin
                read_word = regs_q[i];
            end
        end
    end

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            is_read_q   <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wr_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            is_read_q   <= is_read_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            wr_valid_q  <= wr_valid_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            regs_q      <= regs_d;
        end
    end

    // Next-state: chip select deassertion always wins and returns to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_CMD;
            ST_CMD:  if (n_cs_rise) state_d = ST_IDLE;
                     else if (last_cmd) state_d = ST_DATA;
            ST_DATA: if (n_cs_rise) state_d = ST_IDLE;
                     else if (last_bit) state_d = ST_HOLD;
            ST_HOLD: if (n_cs_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and outputs: shift in on sclk fall, shift out on sclk rise.
    always_comb begin
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        is_read_d   = is_read_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        wr_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        regs_d      = regs_q;
        mosi_meta_d = mosi;
        mosi_sync_d = mosi_meta_q;
        settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        armed_d     = armed_q | ((settle_q == 2'd3) && n_cs_level && sclk_level);

        if (start) begin
            cnt_d     = '0;
            is_read_d = 1'b0;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end else if ((state_q != ST_IDLE) && n_cs_rise) begin
            frame_err_d = in_frame;
            cnt_d       = '0;
            is_read_d   = 1'b0;
            miso_d      = 1'b0;
            miso_oe_d   = 1'b0;
        end else begin
            if (sample) begin
                rx_d  = {rx_q[20:0], mosi_sync_q};
                cnt_d = (cnt_q == CNT_W'(FRAME_LEN)) ? cnt_q : cnt_q + 1'b1;
            end
            if (last_cmd) begin
                is_read_d = cmd_word[7];
                miso_oe_d = cmd_word[7];
                miso_d    = 1'b0;
                tx_d      = cmd_word[7] ? read_word : 16'h0000;
            end
            if (last_bit && !is_read_q) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = frame_addr;
                wr_data_d  = frame_data;
                for (int i = 0; i < N_REGS; i++) begin
                    if (frame_addr == 7'(i)) begin
                        regs_d[i] = frame_data;
                    end
                end
            end
            if (shift_out) begin
                miso_d = tx_q[DATA_LEN-1];
                tx_d   = {tx_q[DATA_LEN-2:0], 1'b0};
            end
        end
    end

    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: directed scenarios plus a
// randomized read/write mix checked against a register-map model.
module tb_spi_reg_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        n_cs = 1'b1;
    logic        sclk = 1'b1;
    logic        mosi = 1'b0;
    logic [15:0] status_in = 16'h0000;
    logic        miso, miso_oe, wr_valid, frame_err;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;

    int n_total = 0;
    int n_pass  = 0;
    int wr_pulses  = 0;
    int err_pulses = 0;
    int oe_cycles  = 0;
    int miso_bad   = 0;

    logic [15:0] model_regs [16];

    always #5 clk = ~clk;

    spi_reg_responder dut (
        .clk       (clk),
        .rst       (rst),
        .n_cs      (n_cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .status_in (status_in),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    // Count pulse cycles and illegal miso activity away from the active edge.
    always @(negedge clk) begin
        if (wr_valid === 1'b1) wr_pulses++;
        if (frame_err === 1'b1) err_pulses++;
        if (miso_oe === 1'b1) oe_cycles++;
        if ((miso === 1'b1) && (miso_oe !== 1'b1)) miso_bad++;
    end

    function automatic logic [15:0] model_read(input logic [6:0] a);
        if (a < 7'd16) return model_regs[a[3:0]];
        if (a == 7'h7F) return status_in;
        return 16'h0000;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [15:0] d);
        if (a < 7'd16) model_regs[a[3:0]] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_regs[i] = 16'h0000;
    endtask

    // One SPI transfer of n_bits sclk cycles (sclk = clk/10); bits past 24 send 0.
    // rst_at >= 0 pulses rst just before that bit's falling edge.
    task automatic spi_xfer(input logic [23:0] word, input int n_bits, input int rst_at,
                            output logic [15:0] rd, output logic oe_ok);
        rd    = 16'h0000;
        oe_ok = 1'b1;
        @(negedge clk);
        n_cs = 1'b0;
        for (int i = 0; i < n_bits; i++) begin
            mosi = (i < 24) ? word[23 - i] : 1'b0;
            #49;
            if (i >= 8 && i < 24) begin
                rd[23 - i] = miso;
                if (miso_oe !== 1'b1) oe_ok = 1'b0;
            end
            #1;
            if (i == rst_at) begin
                rst = 1'b1;
                #30;
                rst = 1'b0;
            end
            sclk = 1'b0;
            #50;
            sclk = 1'b1;
        end
        #50;
        n_cs = 1'b1;
        mosi = 1'b0;
        #100;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_total++; if (miso !== 1'b0) $display("[TB] FAIL reset_miso: got %b expected 0", miso); else n_pass++;
        n_total++; if (miso_oe !== 1'b0) $display("[TB] FAIL reset_miso_oe: got %b expected 0", miso_oe); else n_pass++;
        n_total++; if (wr_valid !== 1'b0) $display("[TB] FAIL reset_wr_valid: got %b expected 0", wr_valid); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); else n_pass++;
        n_total++; if (wr_addr !== 7'h00) $display("[TB] FAIL reset_wr_addr: got %h expected 00", wr_addr); else n_pass++;
        n_total++; if (wr_data !== 16'h0000) $display("[TB] FAIL reset_wr_data: got %h expected 0000", wr_data); else n_pass++;
        rst = 1'b0;
        model_clear();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_write_read();
        int w0, e0;
        logic [15:0] rd;
        logic ok;
        w0 = wr_pulses; e0 = err_pulses;
        spi_xfer(24'h05A5C3, 24, -1, rd, ok);
        model_write(7'h05, 16'hA5C3);
        n_total++; if (wr_pulses - w0 != 1) $display("[TB] FAIL wr_pulse_count: got %0d expected 1", wr_pulses - w0); else n_pass++;
        n_total++; if (err_pulses - e0 != 0) $display("[TB] FAIL wr_frame_err: got %0d expected 0", err_pulses - e0); else n_pass++;
        n_total++; if (wr_addr !== 7'h05) $display("[TB] FAIL wr_addr: got %h expected 05", wr_addr); else n_pass++;
        n_total++; if (wr_data !== 16'hA5C3) $display("[TB] FAIL wr_data: got %h expected a5c3", wr_data); else n_pass++;
        w0 = wr_pulses;
        spi_xfer(24'h850000, 24, -1, rd, ok);
        n_total++; if (rd !== 16'hA5C3) $display("[TB] FAIL read_back: got %h expected a5c3", rd); else n_pass++;
        n_total++; if (ok !== 1'b1) $display("[TB] FAIL read_oe_window: got %b expected 1", ok); else n_pass++;
        n_total++; if (miso_oe !== 1'b0) $display("[TB] FAIL oe_after_cs: got %b expected 0", miso_oe); else n_pass++;
        n_total++; if (wr_pulses - w0 != 0) $display("[TB] FAIL read_no_wr_valid: got %0d expected 0", wr_pulses - w0); else n_pass++;
    endtask

    task automatic test_status();
        int w0;
        logic [15:0] rd;
        logic ok;
        status_in = 16'h1234;
        spi_xfer(24'hFF0000, 24, -1, rd, ok);
        n_total++; if (rd !== 16'h1234) $display("[TB] FAIL status_read: got %h expected 1234", rd); else n_pass++;
        w0 = wr_pulses;
        spi_xfer(24'h7FFFFF, 24, -1, rd, ok);
        n_total++; if (wr_pulses - w0 != 1) $display("[TB] FAIL status_wr_pulse: got %0d expected 1", wr_pulses - w0); else n_pass++;
        n_total++; if (wr_addr !== 7'h7F) $display("[TB] FAIL status_wr_addr: got %h expected 7f", wr_addr); else n_pass++;
        n_total++; if (wr_data !== 16'hFFFF) $display("[TB] FAIL status_wr_data: got %h expected ffff", wr_data); else n_pass++;
        spi_xfer(24'hFF0000, 24, -1, rd, ok);
        n_total++; if (rd !== 16'h1234) $display("[TB] FAIL status_read_after_wr: got %h expected 1234", rd); else n_pass++;
    endtask

    task automatic test_abort();
        int w0, e0;
        logic [15:0] rd;
        logic ok;
        w0 = wr_pulses; e0 = err_pulses;
        spi_xfer(24'h03BEEF, 12, -1, rd, ok);
        n_total++; if (err_pulses - e0 != 1) $display("[TB] FAIL abort_frame_err: got %0d expected 1", err_pulses - e0); else n_pass++;
        n_total++; if (wr_pulses - w0 != 0) $display("[TB] FAIL abort_wr_valid: got %0d expected 0", wr_pulses - w0); else n_pass++;
        spi_xfer(24'h830000, 24, -1, rd, ok);
        n_total++; if (rd !== model_read(7'h03)) $display("[TB] FAIL abort_read: got %h expected %h", rd, model_read(7'h03)); else n_pass++;
    endtask

    task automatic test_extra_clocks();
        int w0, o0;
        logic [15:0] rd;
        logic ok;
        w0 = wr_pulses; o0 = oe_cycles;
        spi_xfer(24'h021111, 30, -1, rd, ok);
        model_write(7'h02, 16'h1111);
        n_total++; if (wr_pulses - w0 != 1) $display("[TB] FAIL extra_wr_pulse: got %0d expected 1", wr_pulses - w0); else n_pass++;
        n_total++; if (oe_cycles - o0 != 0) $display("[TB] FAIL extra_oe_cycles: got %0d expected 0", oe_cycles - o0); else n_pass++;
        n_total++; if (wr_data !== 16'h1111) $display("[TB] FAIL extra_wr_data: got %h expected 1111", wr_data); else n_pass++;
        spi_xfer(24'h820000, 24, -1, rd, ok);
        n_total++; if (rd !== 16'h1111) $display("[TB] FAIL extra_read: got %h expected 1111", rd); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int w0;
        logic [15:0] rd;
        logic ok;
        w0 = wr_pulses;
        spi_xfer(24'h01FFFF, 24, 10, rd, ok);
        model_clear();
        n_total++; if (wr_pulses - w0 != 0) $display("[TB] FAIL midreset_wr_valid: got %0d expected 0", wr_pulses - w0); else n_pass++;
        n_total++; if (wr_addr !== 7'h00) $display("[TB] FAIL midreset_wr_addr: got %h expected 00", wr_addr); else n_pass++;
        spi_xfer(24'h810000, 24, -1, rd, ok);
        n_total++; if (rd !== 16'h0000) $display("[TB] FAIL midreset_read: got %h expected 0000", rd); else n_pass++;
        spi_xfer(24'h820000, 24, -1, rd, ok);
        n_total++; if (rd !== model_read(7'h02)) $display("[TB] FAIL midreset_regs_cleared: got %h expected %h", rd, model_read(7'h02)); else n_pass++;
    endtask

    task automatic test_random();
        int w0;
        logic [15:0] rd, expv, data;
        logic [6:0] addr;
        logic ok;
        for (int n = 0; n < 40; n++) begin
            status_in = 16'($urandom);
            case ($urandom_range(0, 3))
                0, 1: addr = 7'($urandom_range(0, 15));
                2:    addr = 7'h7F;
                default: addr = 7'($urandom_range(16, 126));
            endcase
            data = 16'($urandom);
            w0 = wr_pulses;
            if ($urandom_range(0, 1) == 0) begin
                spi_xfer({1'b0, addr, data}, 24, -1, rd, ok);
                model_write(addr, data);
                n_total++; if (wr_pulses - w0 != 1) $display("[TB] FAIL rnd_wr_pulse[%0d]: got %0d expected 1", n, wr_pulses - w0); else n_pass++;
                n_total++; if ({wr_addr, wr_data} !== {addr, data}) $display("[TB] FAIL rnd_wr_fields[%0d]: got %h/%h expected %h/%h", n, wr_addr, wr_data, addr, data); else n_pass++;
            end else begin
                expv = model_read(addr);
                spi_xfer({1'b1, addr, data}, 24, -1, rd, ok);
                n_total++; if (rd !== expv) $display("[TB] FAIL rnd_read[%0d] addr %h: got %h expected %h", n, addr, rd, expv); else n_pass++;
                n_total++; if (ok !== 1'b1) $display("[TB] FAIL rnd_read_oe[%0d]: got %b expected 1", n, ok); else n_pass++;
            end
        end
    endtask

    initial begin
        $display("[TB] starting spi_reg_responder bench");
        test_reset();
        test_write_read();
        test_status();
        test_abort();
        test_extra_clocks();
        test_reset_midframe();
        test_random();
        n_total++; if (miso_bad != 0) $display("[TB] FAIL miso_without_oe: got %0d cycles expected 0", miso_bad); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
